// File: rtl/win_cmd_gen_if.sv
// Cursor/window command interface: raw buttons and mode in, one-hot command pulses out.
// The command producer (win_cmd_gen) is the master side.
interface win_cmd_gen_if;
   logic [6:0] btn;
   logic       mode;
   logic [6:0] win_ctrl_cmd;

   modport master (
      input  btn,
      input  mode,
      output win_ctrl_cmd
   );

   modport slave (
      output btn,
      output mode,
      input  win_ctrl_cmd
   );
endinterface

// File: rtl/win_cmd_gen.sv
// Push-button front end: synchronise, debounce, edge-detect, auto-repeat move keys,
// and arbitrate pending events into one-hot single-cycle win_ctrl_cmd pulses.
module win_cmd_gen #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000,
   parameter int CNT_W           = 25
) (
   input  logic          clk,
   input  logic          rst,
   win_cmd_gen_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_REPEAT  = 2'd2
   } btn_state_t;

   // Only the four movement keys auto-repeat; bit 4 is the mode-gated toggle.
   localparam logic [6:0]       REP_MASK    = 7'h0F;
   localparam logic [6:0]       NO_TOGGLE   = 7'h6F;
   localparam logic [6:0]       ALL_BITS    = 7'h7F;
   localparam logic [CNT_W-1:0] DEB_MAX     = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] DLY_LAST    = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST    = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic [6:0]       sync1_r;
   logic [6:0]       s_r;
   logic [6:0]       deb_r;
   logic [6:0]       pending_r;
   logic [6:0]       cmd_r;
   logic [CNT_W-1:0] dcnt_r [7];
   logic [CNT_W-1:0] rcnt_r [7];
   btn_state_t       state_r [7];

   logic [6:0] deb_next_s;
   logic [6:0] rise_s;
   logic [6:0] fall_s;
   logic [6:0] rep_hit_s;
   logic [6:0] event_s;
   logic [6:0] keep_s;
   logic [6:0] elig_s;
   logic [6:0] issue_s;
   logic [6:0] pending_next_s;

   // Two-flop synchroniser for the asynchronous button levels.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r <= 7'd0;
         s_r     <= 7'd0;
      end else begin
         sync1_r <= bus.btn;
         s_r     <= sync1_r;
      end
   end

   // Debounced level flips once the mismatch counter has already reached its limit.
   always_comb begin
      deb_next_s = deb_r;
      for (int i = 0; i < 7; i++) begin
         if ((s_r[i] != deb_r[i]) && (dcnt_r[i] == DEB_MAX)) begin
            deb_next_s[i] = s_r[i];
         end else begin
            deb_next_s[i] = deb_r[i];
         end
      end
   end

   assign rise_s = deb_next_s & ~deb_r;
   assign fall_s = deb_r & ~deb_next_s;

   // Debounce mismatch counters and debounced state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_r <= 7'd0;
         for (int i = 0; i < 7; i++) begin
            dcnt_r[i] <= CNT_ZERO;
         end
      end else begin
         deb_r <= deb_next_s;
         for (int i = 0; i < 7; i++) begin
            if ((s_r[i] == deb_r[i]) || (dcnt_r[i] == DEB_MAX)) begin
               dcnt_r[i] <= CNT_ZERO;
            end else begin
               dcnt_r[i] <= dcnt_r[i] + CNT_ONE;
            end
         end
      end
   end

   // Auto-repeat hit for held move keys; a release on the same edge suppresses it.
   always_comb begin
      rep_hit_s = 7'd0;
      for (int i = 0; i < 7; i++) begin
         case (state_r[i])
            ST_PRESSED: rep_hit_s[i] = REP_MASK[i] && !fall_s[i] && (rcnt_r[i] == DLY_LAST);
            ST_REPEAT:  rep_hit_s[i] = !fall_s[i] && (rcnt_r[i] == PER_LAST);
            default:    rep_hit_s[i] = 1'b0;
         endcase
      end
   end

   // Per-button press/repeat state machine with its repeat counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 7; i++) begin
            state_r[i] <= ST_IDLE;
            rcnt_r[i]  <= CNT_ZERO;
         end
      end else begin
         for (int i = 0; i < 7; i++) begin
            case (state_r[i])
               ST_IDLE: begin
                  rcnt_r[i] <= CNT_ZERO;
                  if (rise_s[i]) begin
                     state_r[i] <= ST_PRESSED;
                  end
               end
               ST_PRESSED: begin
                  if (fall_s[i]) begin
                     state_r[i] <= ST_IDLE;
                     rcnt_r[i]  <= CNT_ZERO;
                  end else if (rep_hit_s[i]) begin
                     state_r[i] <= ST_REPEAT;
                     rcnt_r[i]  <= CNT_ZERO;
                  end else if (REP_MASK[i]) begin
                     rcnt_r[i]  <= rcnt_r[i] + CNT_ONE;
                  end
               end
               ST_REPEAT: begin
                  if (fall_s[i]) begin
                     state_r[i] <= ST_IDLE;
                     rcnt_r[i]  <= CNT_ZERO;
                  end else if (rep_hit_s[i]) begin
                     rcnt_r[i]  <= CNT_ZERO;
                  end else begin
                     rcnt_r[i]  <= rcnt_r[i] + CNT_ONE;
                  end
               end
               default: begin
                  state_r[i] <= ST_IDLE;
                  rcnt_r[i]  <= CNT_ZERO;
               end
            endcase
         end
      end
   end

   assign event_s = rise_s | rep_hit_s;

   // Lowest-index eligible pending bit wins; a same-cycle event re-arms the issued bit.
   always_comb begin
      if (bus.mode) begin
         keep_s = NO_TOGGLE;
      end else begin
         keep_s = ALL_BITS;
      end
      elig_s         = pending_r & keep_s;
      issue_s        = elig_s & (~elig_s + 7'd1);
      pending_next_s = ((pending_r & ~issue_s) | event_s) & keep_s;
   end

   // Pending set and registered command pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_r <= 7'd0;
         cmd_r     <= 7'd0;
      end else begin
         pending_r <= pending_next_s;
         cmd_r     <= issue_s;
      end
   end

   assign bus.win_ctrl_cmd = cmd_r;

endmodule

// File: tb/tb_win_cmd_gen.sv
// Self-checking bench for win_cmd_gen: edge-indexed behavioural model plus directed
// timing checks and a randomised button/mode soak.
module tb_win_cmd_gen;
   localparam int D = 4;
   localparam int R = 20;
   localparam int T = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   win_cmd_gen_if bus();

   win_cmd_gen #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(R),
      .REPEAT_PERIOD(T),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc      = 0;

   // model state
   logic [6:0] m_sync1;
   logic [6:0] m_deb;
   logic [6:0] m_pend;
   logic [6:0] m_cmd;
   logic [6:0] m_s_hist[$];
   int         m_edge;
   int         m_rise[7];

   // pulse log for directed timing checks
   int         pulse_cyc[$];
   logic [6:0] pulse_val[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_sync1 = 7'd0;
      m_deb   = 7'd0;
      m_pend  = 7'd0;
      m_cmd   = 7'd0;
      m_edge  = 0;
      m_s_hist.delete();
      for (int k = 0; k <= D; k++) m_s_hist.push_back(7'd0);
      for (int i = 0; i < 7; i++) m_rise[i] = 0;
   endtask

   // One clock edge of the behavioural model. History holds synchronised values
   // seen over the last D+1 cycles; deb flips when all of them disagree with it.
   task automatic model_step();
      logic [6:0] dn, ev, elig, iss;
      bit flip, found;
      int age;
      ev = 7'd0;
      dn = m_deb;
      for (int i = 0; i < 7; i++) begin
         flip = 1'b1;
         for (int k = 0; k < m_s_hist.size(); k++)
            if (m_s_hist[k][i] == m_deb[i]) flip = 1'b0;
         if (flip) dn[i] = ~m_deb[i];
         if (dn[i] && !m_deb[i]) begin
            ev[i] = 1'b1;
            m_rise[i] = m_edge;
         end else if (dn[i] && m_deb[i] && i < 4) begin
            age = m_edge - m_rise[i];
            if (age == R || (age > R && ((age - R) % T) == 0)) ev[i] = 1'b1;
         end
      end
      elig = m_pend;
      if (bus.mode) elig[4] = 1'b0;
      iss = 7'd0;
      found = 1'b0;
      for (int i = 0; i < 7; i++)
         if (elig[i] && !found) begin
            iss[i] = 1'b1;
            found = 1'b1;
         end
      m_pend = (m_pend & ~iss) | ev;
      if (bus.mode) m_pend[4] = 1'b0;
      m_cmd = iss;
      m_s_hist.push_back(m_sync1);
      void'(m_s_hist.pop_front());
      m_sync1 = bus.btn;
      m_deb = dn;
      m_edge++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (!rst) model_reset();
         else model_step();
      end
   end

   // cycle-by-cycle compare against the model, plus pulse logging
   initial begin
      forever begin
         @(negedge clk);
         check("cmd", bus.win_ctrl_cmd, m_cmd);
         check("onehot0", ($countones(bus.win_ctrl_cmd) <= 1) ? 1 : 0, 1);
         if (bus.win_ctrl_cmd != 7'd0) begin
            pulse_cyc.push_back(cyc);
            pulse_val.push_back(bus.win_ctrl_cmd);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      pulse_cyc.delete();
      pulse_val.delete();
   endtask

   task automatic run_press(input logic [6:0] v, input int hold, input int settle, output int c0);
      clear_log();
      c0 = cyc;
      bus.btn = v;
      tick(hold);
      bus.btn = 7'd0;
      tick(settle);
   endtask

   // edge index (edge 0 = first sampling of the new input) at which log entry i was issued
   function automatic int off(input int i, input int c0);
      return pulse_cyc[i] - c0 - 1;
   endfunction

   int c0;
   int rep_exp[6] = '{7, 27, 35, 43, 51, 59};

   initial begin
      bus.btn  = 7'h7F;
      bus.mode = 1'b0;
      rst      = 1'b0;
      tick(5);
      check("rst_quiet", pulse_cyc.size(), 0);

      // reset release with all buttons held
      clear_log();
      c0 = cyc;
      rst = 1'b1;
      tick(16);
      check("rst_cnt", pulse_cyc.size(), 7);
      for (int i = 0; i < pulse_cyc.size() && i < 7; i++) begin
         check("rst_off", off(i, c0), 7 + i);
         check("rst_val", pulse_val[i], 32'd1 << i);
      end
      bus.btn = 7'd0;
      tick(40);

      // single press, no repeat
      run_press(7'h08, 12, 20, c0);
      check("single_cnt", pulse_cyc.size(), 1);
      if (pulse_cyc.size() > 0) begin
         check("single_off", off(0, c0), 7);
         check("single_val", pulse_val[0], 7'h08);
      end

      // bounce then hold
      clear_log();
      for (int k = 0; k < 5; k++) begin
         bus.btn = 7'h10;
         tick(2);
         bus.btn = 7'h00;
         tick(2);
      end
      c0 = cyc;
      bus.btn = 7'h10;
      tick(12);
      bus.btn = 7'h00;
      tick(20);
      check("bounce_cnt", pulse_cyc.size(), 1);
      if (pulse_cyc.size() > 0) begin
         check("bounce_off", off(0, c0), 7);
         check("bounce_val", pulse_val[0], 7'h10);
      end

      // auto-repeat on up
      run_press(7'h01, 60, 30, c0);
      check("rep_cnt", pulse_cyc.size(), 6);
      for (int i = 0; i < pulse_cyc.size() && i < 6; i++) begin
         check("rep_off", off(i, c0), rep_exp[i]);
         check("rep_val", pulse_val[i], 7'h01);
      end

      // zoom in never repeats
      run_press(7'h20, 60, 30, c0);
      check("zoom_cnt", pulse_cyc.size(), 1);
      if (pulse_cyc.size() > 0) check("zoom_val", pulse_val[0], 7'h20);

      // arbitration of simultaneous presses
      run_press(7'h54, 12, 20, c0);
      check("arb_cnt", pulse_cyc.size(), 3);
      if (pulse_cyc.size() == 3) begin
         check("arb_v0", pulse_val[0], 7'h04);
         check("arb_v1", pulse_val[1], 7'h10);
         check("arb_v2", pulse_val[2], 7'h40);
         check("arb_o0", off(0, c0), 7);
         check("arb_o2", off(2, c0), 9);
      end

      // toggle pressed in run mode
      bus.mode = 1'b1;
      run_press(7'h10, 12, 20, c0);
      check("mode_cnt", pulse_cyc.size(), 0);
      bus.mode = 1'b0;

      // toggle pending behind a lower bit when run mode arrives
      clear_log();
      c0 = cyc;
      bus.btn = 7'h11;
      tick(7);
      bus.mode = 1'b1;
      tick(5);
      bus.btn = 7'h00;
      tick(20);
      bus.mode = 1'b0;
      check("drop_cnt", pulse_cyc.size(), 1);
      if (pulse_cyc.size() > 0) begin
         check("drop_val", pulse_val[0], 7'h01);
         check("drop_off", off(0, c0), 7);
      end

      // randomised soak checked by the model
      for (int seg = 0; seg < 300; seg++) begin
         if (seg == 150) begin
            #1 rst = 1'b0;
            tick(3);
            rst = 1'b1;
         end
         bus.btn = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
         tick($urandom_range(1, 30));
      end
      bus.btn  = 7'd0;
      bus.mode = 1'b0;
      tick(40);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
